// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the byte-enabled simple dual-port RAM.
package sdp_ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Read-during-write collision behaviour
  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  function automatic int unsigned num_bytes(input int unsigned data_width,
                                            input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/sdp_ram_array.sv
// Bare storage: byte-enabled write port, registered read data, no reset.
module sdp_ram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_BYTES-1:0]  wbe_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // One narrow array per lane keeps each lane's write enable independent
  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
    logic [BYTE_WIDTH-1:0] lane_q [DEPTH];
    logic [BYTE_WIDTH-1:0] rdata_q;

    // Lane write and read; a same-address read returns the pre-write value
    always_ff @(posedge clk) begin
      if (we_i && wbe_i[b]) begin
        lane_q[waddr_i] <= wdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (re_i) begin
        rdata_q <= lane_q[raddr_i];
      end
    end

    assign rdata_o[b*BYTE_WIDTH +: BYTE_WIDTH] = rdata_q;
  end

endmodule

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with byte enables, selectable read latency,
// read-during-write control, read-valid strobe and a clear sequencer.
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  output logic                  busy_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_BYTES-1:0]  wr_be_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("sdp_ram_be: READ_LATENCY must be 1 or 2");
  end

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy;

  assign busy   = (state_q == ST_CLEAR);
  assign busy_o = busy;

  // Clear sequencer: sweep every address once, clr only honoured when idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [NUM_BYTES-1:0]  arr_wbe;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  arr_re;
  logic [ADDR_WIDTH-1:0] arr_raddr;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  rd_acc;
  logic                  rd_valid;

  // Write mux: the sweep owns the write port while busy
  always_comb begin
    if (busy) begin
      arr_we    = 1'b1;
      arr_waddr = cnt_q;
      arr_wbe   = '1;
      arr_wdata = '0;
    end else begin
      arr_we    = wr_en_i;
      arr_waddr = wr_addr_i;
      arr_wbe   = wr_be_i;
      arr_wdata = wr_data_i;
    end
  end

  assign rd_acc = rd_en_i & ~busy;

  if (READ_LATENCY == 1) begin : g_lat1
    logic valid_q;

    // Array is read in the request cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= rd_acc;
    end

    assign arr_re    = rd_acc;
    assign arr_raddr = rd_addr_i;
    assign rd_valid  = valid_q;
  end else begin : g_lat2
    logic                  req_q;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] raddr_q;

    // Register the request; the array is read one cycle later. Accepted
    // requests run to completion even if a sweep starts behind them.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        req_q   <= 1'b0;
        valid_q <= 1'b0;
        raddr_q <= '0;
      end else begin
        req_q   <= rd_acc;
        valid_q <= req_q;
        if (rd_acc) raddr_q <= rd_addr_i;
      end
    end

    assign arr_re    = req_q;
    assign arr_raddr = raddr_q;
    assign rd_valid  = valid_q;
  end

  sdp_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .waddr_i(arr_waddr),
    .wbe_i  (arr_wbe),
    .wdata_i(arr_wdata),
    .re_i   (arr_re),
    .raddr_i(arr_raddr),
    .rdata_o(arr_rdata)
  );

  logic [DATA_WIDTH-1:0] rd_merged;

  if (RDW_MODE == RDW_NEW) begin : g_rdw_new
    logic [NUM_BYTES-1:0]  fwd_be_d;
    logic [NUM_BYTES-1:0]  fwd_be_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    assign fwd_be_d = (arr_re && arr_we && (arr_waddr == arr_raddr)) ? arr_wbe : '0;

    // Capture lanes written during the array-read cycle for forwarding
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fwd_be_q   <= '0;
        fwd_data_q <= '0;
      end else begin
        fwd_be_q <= fwd_be_d;
        if (|fwd_be_d) fwd_data_q <= arr_wdata;
      end
    end

    // Forwarded lanes override the stale array data lane by lane
    always_comb begin
      rd_merged = arr_rdata;
      for (int b = 0; b < int'(NUM_BYTES); b++) begin
        if (fwd_be_q[b]) begin
          rd_merged[b*BYTE_WIDTH +: BYTE_WIDTH] = fwd_data_q[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end else begin : g_rdw_old
    assign rd_merged = arr_rdata;
  end

  logic [DATA_WIDTH-1:0] rd_hold_q;

  // Holds the last returned word so rd_data is stable and resets to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rd_hold_q <= '0;
    else if (rd_valid) rd_hold_q <= rd_merged;
  end

  assign rd_data_o  = rd_valid ? rd_merged : rd_hold_q;
  assign rd_valid_o = rd_valid;

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed bench: instance A uses latency 2 / old-data collisions, instance B
// latency 1 / forwarded collisions; both share the same stimulus.
module tb_sdp_ram_be;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned NB    = 4;
  localparam int unsigned DEPTH = 64;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          busy_a, busy_b, rd_valid_a, rd_valid_b;
  logic [DW-1:0] rd_data_a, rd_data_b;

  int vectors     = 0;
  int miscompares = 0;
  int n;
  logic [DW-1:0] exp_mem [DEPTH];

  always #5 clk = ~clk;

  sdp_ram_be #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6),
    .READ_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy_a),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a)
  );

  sdp_ram_be #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6),
    .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (exp_mem[i]) exp_mem[i] = '0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    step();
    wr_en = 1'b0; wr_be = '0;
    for (int b = 0; b < int'(NB); b++) begin
      if (be[b]) exp_mem[addr][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic read_one(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    rd_en = 1'b1; rd_addr = addr;
    step();
    rd_en = 1'b0;
    chk({tag, "_valid_b"}, rd_valid_b, 1);
    chk({tag, "_data_b"}, rd_data_b, exp);
    chk({tag, "_early_a"}, rd_valid_a, 0);
    step();
    chk({tag, "_valid_a"}, rd_valid_a, 1);
    chk({tag, "_data_a"}, rd_data_a, exp);
    chk({tag, "_done_b"}, rd_valid_b, 0);
    chk({tag, "_hold_b"}, rd_data_b, exp);
  endtask

  // Back-to-back reads; valid checked every cycle so any bubble is caught
  task automatic read_stream(input int base, input int cnt);
    for (int i = 0; i < cnt + 2; i++) begin
      rd_en   = (i < cnt);
      rd_addr = AW'(base + i);
      step();
      if (i < cnt) begin
        chk("stream_valid_b", rd_valid_b, 1);
        chk("stream_data_b", rd_data_b, exp_mem[base+i]);
      end else begin
        chk("stream_idle_b", rd_valid_b, 0);
      end
      if (i >= 1 && i <= cnt) begin
        chk("stream_valid_a", rd_valid_a, 1);
        chk("stream_data_a", rd_data_a, exp_mem[base+i-1]);
      end else begin
        chk("stream_idle_a", rd_valid_a, 0);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 200) begin
      chk("sweep_busy_b", busy_b, 1);
      cycles++;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy_a", busy_a, 1);
    chk("rst_busy_b", busy_b, 1);
    chk("rst_valid_a", rd_valid_a, 0);
    chk("rst_data_a", rd_data_a, 0);
    chk("rst_valid_b", rd_valid_b, 0);
    step(); step();
    rst_n = 1'b1;
    count_busy(n);
    chk("rst_sweep_len", n, 64);
    model_clear();
    read_stream(0, 64);

    // Byte enables
    wr(6'd5, 32'h11223344, 4'hF);
    wr(6'd5, 32'hAABBCCDD, 4'b0101);
    read_one("be_mix", 6'd5, 32'h11BB33DD);
    wr(6'd5, 32'hFFFFFFFF, 4'h0);
    read_one("be_none", 6'd5, 32'h11BB33DD);

    // Same-cycle write and read of addr 9 (holds zero)
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 6'd9;
    step();
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    chk("coll_t_valid_b", rd_valid_b, 1);
    chk("coll_t_data_b", rd_data_b, 32'hDEADBEEF);
    step();
    chk("coll_t_valid_a", rd_valid_a, 1);
    chk("coll_t_data_a", rd_data_a, 32'hDEADBEEF);
    exp_mem[9] = 32'hDEADBEEF;

    // Read of addr 10 at t, write at t+1 (A's array-read cycle)
    rd_en = 1'b1; rd_addr = 6'd10;
    step();
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    chk("coll_t1_valid_b", rd_valid_b, 1);
    chk("coll_t1_data_b", rd_data_b, 32'h0);
    step();
    wr_en = 1'b0; wr_be = '0;
    chk("coll_t1_valid_a", rd_valid_a, 1);
    chk("coll_t1_data_a", rd_data_a, 32'h0);
    exp_mem[10] = 32'hCAFEF00D;
    read_one("coll_t1_commit", 6'd10, 32'hCAFEF00D);

    // Partial-lane collision: B forwards low lanes only
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'h55667788; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 6'd5;
    step();
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    chk("coll_part_data_b", rd_data_b, 32'h11BB7788);
    step();
    chk("coll_part_data_a", rd_data_a, 32'h11BB7788);

    // Partial-lane collision in A's array-read cycle: old data returned
    rd_en = 1'b1; rd_addr = 6'd5;
    step();
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'h99AA0000; wr_be = 4'b1100;
    chk("coll_old_data_b", rd_data_b, 32'h11BB7788);
    step();
    wr_en = 1'b0; wr_be = '0;
    chk("coll_old_data_a", rd_data_a, 32'h11BB7788);
    read_one("coll_old_commit", 6'd5, 32'h99AA7788);

    // Streaming reads of 0..15
    for (int i = 0; i < 16; i++) begin
      wr(AW'(i), {8'(i), 8'hA5, ~8'(i), 8'h3C}, 4'hF);
    end
    read_stream(0, 16);

    // clr in idle; requests ignored while busy; a second clr mid-sweep ignored
    clr = 1'b1;
    step();
    clr = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = '1; wr_be = '1;
    rd_en = 1'b1; rd_addr = 6'd3;
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin
      chk("clr_valid_a", rd_valid_a, 0);
      chk("clr_valid_b", rd_valid_b, 0);
      chk("clr_busy_b", busy_b, 1);
      n++;
      clr = (n == 20);
      step();
    end
    clr = 1'b0; wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    chk("clr_len", n, 64);
    chk("clr_exit_valid_b", rd_valid_b, 0);
    step();
    chk("clr_exit_valid_a", rd_valid_a, 0);
    model_clear();
    read_stream(0, 64);

    // Read accepted in the clr cycle still completes
    wr(6'd7, 32'h12345678, 4'hF);
    rd_en = 1'b1; rd_addr = 6'd7; clr = 1'b1;
    step();
    rd_en = 1'b0; clr = 1'b0;
    chk("pre_clr_busy_a", busy_a, 1);
    chk("pre_clr_valid_b", rd_valid_b, 1);
    chk("pre_clr_data_b", rd_data_b, 32'h12345678);
    step();
    chk("pre_clr_valid_a", rd_valid_a, 1);
    chk("pre_clr_data_a", rd_data_a, 32'h12345678);
    count_busy(n);
    chk("pre_clr_rest_len", n, 63);
    model_clear();

    // Reset with a read in flight discards it
    wr(6'd7, 32'h0BADF00D, 4'hF);
    rd_en = 1'b1; rd_addr = 6'd7;
    step();
    rd_en = 1'b0;
    chk("flight_valid_b", rd_valid_b, 1);
    rst_n = 1'b0;
    #1;
    chk("flight_rst_valid_a", rd_valid_a, 0);
    chk("flight_rst_data_a", rd_data_a, 0);
    chk("flight_rst_valid_b", rd_valid_b, 0);
    chk("flight_rst_data_b", rd_data_b, 0);
    chk("flight_rst_busy_a", busy_a, 1);
    step(); step();
    rst_n = 1'b1;
    count_busy(n);
    chk("flight_sweep_len", n, 64);
    read_one("flight_post", 6'd7, 32'h0);

    // Reset at sweep cycle 20 restarts a full sweep
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (19) step();
    chk("mid_busy_before", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_a", busy_a, 1);
    chk("mid_rst_valid_a", rd_valid_a, 0);
    chk("mid_rst_valid_b", rd_valid_b, 0);
    step();
    rst_n = 1'b1;
    count_busy(n);
    chk("mid_sweep_len", n, 64);
    read_one("mid_post", 6'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
